bitwise_op_arbiter: RTL and testbench

//   Round-robin arbiter and sequencer sharing one W-bit bitwise logic unit (AND/OR/BUF/NOT gate arrays) among N requesters.

---
 rtl/bitwise_pkg.sv | 13 +
 rtl/bitwise_unit.sv | 35 +++
 rtl/bitwise_op_arbiter.sv | 129 ++++++++++++
 tb/tb_bitwise_op_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitwise_pkg.sv
// Shared encodings for the bitwise arbiter: operation codes and FSM state values.
package bitwise_pkg;

  localparam logic [1:0] OP_AND = 2'd0;
  localparam logic [1:0] OP_OR  = 2'd1;
  localparam logic [1:0] OP_BUF = 2'd2;
  localparam logic [1:0] OP_NOT = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/bitwise_unit.sv
// Shared combinational logic unit: per-bit AND/OR/BUF/NOT gate arrays with an op-selected output.
module bitwise_unit
  import bitwise_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  logic [W-1:0] and_y_s;
  logic [W-1:0] or_y_s;
  logic [W-1:0] buf_y_s;
  logic [W-1:0] not_y_s;

  for (genvar i = 0; i < W; i++) begin : g_bit
    and u_and (and_y_s[i], a[i], b[i]);
    or  u_or  (or_y_s[i],  a[i], b[i]);
    buf u_buf (buf_y_s[i], a[i]);
    not u_not (not_y_s[i], a[i]);
  end

  // Result select; the default arm is the NOT encoding.
  always_comb begin
    case (op)
      OP_AND:  y = and_y_s;
      OP_OR:   y = or_y_s;
      OP_BUF:  y = buf_y_s;
      default: y = not_y_s;
    endcase
  end

endmodule

// File: rtl/bitwise_op_arbiter.sv
// Round-robin arbiter/sequencer sharing one bitwise_unit among N requesters;
// one operation per grant, tagged response two cycles after the grant.
module bitwise_op_arbiter
  import bitwise_pkg::*;
#(
  parameter int N   = 4,
  parameter int W   = 32,
  parameter int IDW = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [2*N-1:0]   op,
  input  logic [W*N-1:0]   a,
  input  logic [W*N-1:0]   b,
  output logic [N-1:0]     gnt,
  output logic             busy,
  output logic             rsp_valid,
  output logic [IDW-1:0]   rsp_id,
  output logic [W-1:0]     rsp_data
);

  logic [1:0]     state_r;
  logic [IDW-1:0] last_id_r;
  logic [IDW-1:0] id_r;
  logic [1:0]     op_r;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic           rsp_valid_r;
  logic [IDW-1:0] rsp_id_r;
  logic [W-1:0]   rsp_data_r;

  logic           found_s;
  logic [IDW-1:0] win_s;
  logic [1:0]     sel_op_s;
  logic [W-1:0]   sel_a_s;
  logic [W-1:0]   sel_b_s;
  logic [N-1:0]   gnt_s;
  logic [W-1:0]   unit_y_s;

  // Priority scan starting just after the last granted requester, wrapping modulo N.
  always_comb begin
    found_s  = 1'b0;
    win_s    = {IDW{1'b0}};
    sel_op_s = 2'b00;
    sel_a_s  = {W{1'b0}};
    sel_b_s  = {W{1'b0}};
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (int'(last_id_r) + k) % N;
      if (!found_s && req[idx]) begin
        found_s  = 1'b1;
        win_s    = IDW'(idx);
        sel_op_s = op[2*idx +: 2];
        sel_a_s  = a[W*idx +: W];
        sel_b_s  = b[W*idx +: W];
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Grant is only ever issued from IDLE, and only to the scan winner.
  always_comb begin
    gnt_s = {N{1'b0}};
    if ((state_r == ST_IDLE) && found_s) begin
      gnt_s[win_s] = 1'b1;
    end else begin
      gnt_s = {N{1'b0}};
    end
  end

  // Sequencer FSM: capture the winner's operation on grant, then EXEC and RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      last_id_r <= IDW'(N - 1);
      id_r      <= {IDW{1'b0}};
      op_r      <= 2'b00;
      a_r       <= {W{1'b0}};
      b_r       <= {W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            state_r   <= ST_EXEC;
            last_id_r <= win_s;
            id_r      <= win_s;
            op_r      <= sel_op_s;
            a_r       <= sel_a_s;
            b_r       <= sel_b_s;
          end
        end
        ST_EXEC: state_r <= ST_RESP;
        ST_RESP: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  bitwise_unit #(.W(W)) u_unit (
    .op (op_r),
    .a  (a_r),
    .b  (b_r),
    .y  (unit_y_s)
  );

  // Response registers: result and tag captured in EXEC, valid high exactly in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= {IDW{1'b0}};
      rsp_data_r  <= {W{1'b0}};
    end else begin
      rsp_valid_r <= (state_r == ST_EXEC);
      if (state_r == ST_EXEC) begin
        rsp_id_r   <= id_r;
        rsp_data_r <= unit_y_s;
      end
    end
  end

  assign gnt       = gnt_s;
  assign busy      = (state_r != ST_IDLE);
  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_data  = rsp_data_r;

endmodule

// File: tb/tb_bitwise_op_arbiter.sv
// Scoreboard bench for bitwise_op_arbiter: directed scenarios plus a random handshake phase.
module tb_bitwise_op_arbiter;
  import bitwise_pkg::*;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req;
  logic [2*N-1:0]   op;
  logic [W*N-1:0]   a;
  logic [W*N-1:0]   b;
  logic [N-1:0]     gnt;
  logic             busy;
  logic             rsp_valid;
  logic [IDW-1:0]   rsp_id;
  logic [W-1:0]     rsp_data;

  int checks = 0;
  int errors = 0;

  int mdl_state = 0;
  int mdl_last  = N - 1;
  int cyc       = 0;
  logic [IDW+W-1:0] sb_q[$];
  int gnt_ids[$];
  int gnt_cyc[$];
  logic [N-1:0] granted = 4'b0000;

  bitwise_op_arbiter #(.N(N), .W(W), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .op        (op),
    .a         (a),
    .b         (b),
    .gnt       (gnt),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    case (o)
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_BUF:  return x;
      default: return ~x;
    endcase
  endfunction

  // Reference model and scoreboard, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      granted = 4'b0000;
      if (!rst_n) begin
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_valid", rsp_valid, 1'b0);
        mdl_state = 0;
        mdl_last  = N - 1;
        sb_q.delete();
      end else begin
        int win;
        logic [N-1:0] exp_gnt;
        logic [IDW+W-1:0] e;
        win = -1;
        exp_gnt = 4'b0000;
        if (mdl_state == 0) begin
          for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (mdl_last + k) % N;
            if (win < 0 && req[idx]) win = idx;
          end
        end
        if (win >= 0) exp_gnt[win] = 1'b1;
        check_val("gnt", gnt, exp_gnt);
        check_val("busy", busy, mdl_state != 0);
        check_val("rsp_valid", rsp_valid, mdl_state == 2);
        if (rsp_valid) begin
          if (sb_q.size() == 0) begin
            check_val("sb_underflow", 1'b1, 1'b0);
          end else begin
            e = sb_q.pop_front();
            check_val("rsp_id", rsp_id, e[W +: IDW]);
            check_val("rsp_data", rsp_data, e[W-1:0]);
          end
        end
        if (win >= 0) begin
          sb_q.push_back({IDW'(win), model_op(op[2*win +: 2], a[W*win +: W], b[W*win +: W])});
          mdl_last  = win;
          mdl_state = 1;
          gnt_ids.push_back(win);
          gnt_cyc.push_back(cyc);
          granted = exp_gnt;
        end else if (mdl_state == 1) begin
          mdl_state = 2;
        end else if (mdl_state == 2) begin
          mdl_state = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
    op[2*i +: 2] = o;
    a[W*i +: W]  = av;
    b[W*i +: W]  = bv;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Single requester issues while the arbiter is idle, then drops its request.
  task automatic issue(input int i, input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
    set_req(i, o, av, bv);
    req    = 4'b0000;
    req[i] = 1'b1;
    step();
    req    = 4'b0000;
  endtask

  task automatic wait_rsp(input string tag, input logic [IDW-1:0] eid, input logic [W-1:0] edata, output int lat);
    lat = 0;
    while (lat < 10) begin
      step();
      lat++;
      if (rsp_valid) break;
    end
    if (!rsp_valid) begin
      check_val({tag, "_timeout"}, 1'b0, 1'b1);
    end else begin
      check_val({tag, "_id"}, rsp_id, eid);
      check_val({tag, "_data"}, rsp_data, edata);
    end
  endtask

  initial begin
    int lat;
    int n0;
    rst_n = 1'b0;
    req   = 4'b0000;
    op    = 8'h00;
    a     = {(W*N){1'b0}};
    b     = {(W*N){1'b0}};
    step();
    check_val("reset_gnt", gnt, 4'b0000);
    check_val("reset_rsp_id", rsp_id, 2'd0);
    check_val("reset_rsp_data", rsp_data, 32'h0000_0000);
    step();
    rst_n = 1'b1;

    // Single AND request, latency to response.
    issue(0, OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF);
    wait_rsp("t1", 2'd0, 32'h00F0_1234, lat);
    check_val("t1_latency", lat, 1);
    step();

    // All requesters held high: round-robin order and grant spacing.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 2'(i), 32'h1111_1111 * (i + 1), 32'h0F0F_0F0F);
    req = 4'b1111;
    n0 = gnt_ids.size();
    for (int s = 0; s < 40; s++) begin
      step();
      if (gnt_ids.size() >= n0 + 5) break;
    end
    req = 4'b0000;
    check_val("t2_count", gnt_ids.size() >= n0 + 5, 1'b1);
    if (gnt_ids.size() >= n0 + 5) begin
      for (int k = 0; k < 5; k++) check_val("t2_order", gnt_ids[n0+k], k % N);
      for (int k = 1; k < 5; k++) check_val("t2_gap", gnt_cyc[n0+k] - gnt_cyc[n0+k-1], 3);
    end
    for (int s = 0; s < 4; s++) step();

    // OR on requester 2 sets last_id=2, then wrap to 0 and on to 1 (NOT).
    do_reset();
    issue(2, OP_OR, 32'h0000_0001, 32'h0000_0008);
    wait_rsp("t4_or", 2'd2, 32'h0000_0009, lat);
    step();
    set_req(0, OP_BUF, 32'hCAFE_BABE, 32'h0000_0000);
    set_req(1, OP_NOT, 32'h0000_00FF, 32'h1234_5678);
    req = 4'b0011;
    n0 = gnt_ids.size();
    step();
    req = 4'b0010;
    wait_rsp("t3_buf", 2'd0, 32'hCAFE_BABE, lat);
    step();
    step();
    req = 4'b0000;
    wait_rsp("t4_not", 2'd1, 32'hFFFF_FF00, lat);
    check_val("t3_count", gnt_ids.size(), n0 + 2);
    if (gnt_ids.size() >= n0 + 2) begin
      check_val("t3_wrap", gnt_ids[n0], 0);
      check_val("t3_next", gnt_ids[n0+1], 1);
    end
    step();

    // Reset during EXEC abandons the operation; first grant after goes to lowest set bit.
    issue(3, OP_AND, 32'hFFFF_0000, 32'h00FF_FF00);
    rst_n = 1'b0;
    #1;
    check_val("t5_busy_now", busy, 1'b0);
    check_val("t5_valid_now", rsp_valid, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    set_req(1, OP_OR, 32'hA000_0000, 32'h0000_000A);
    set_req(3, OP_NOT, 32'h0, 32'h0);
    req = 4'b1010;
    n0 = gnt_ids.size();
    step();
    req = 4'b0000;
    check_val("t5_count", gnt_ids.size(), n0 + 1);
    if (gnt_ids.size() >= n0 + 1) check_val("t5_first", gnt_ids[n0], 1);
    wait_rsp("t5_rsp", 2'd1, 32'hA000_000A, lat);
    step();

    // Random traffic: requesters drop or reissue after each grant.
    for (int s = 0; s < 400; s++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (granted[i] || !req[i]) begin
          if ($urandom_range(2, 0) == 0 && granted[i]) begin
            req[i] = 1'b0;
          end else if (granted[i] || $urandom_range(2, 0) == 0) begin
            set_req(i, 2'($urandom_range(3, 0)), $urandom, $urandom);
            req[i] = 1'b1;
          end
        end
      end
    end
    req = 4'b0000;
    for (int s = 0; s < 6; s++) step();
    check_val("sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
